// File: rtl/arg_frame_collector.sv
// arg_frame_collector: gathers a framed run of arguments (arg_last marks the
//   final one), sums them modulo 2^W and reports sum, arity error and count.
// Latency: res_valid rises on the clock edge that accepts the arg_last beat.
// Backpressure: arg_ready drops for the whole RESULT phase; the result is held
//   stable until res_ready is seen, so frames never overlap.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   arg_valid/arg_ready      - argument handshake (arg_ready is state-only)
//   arg_data, arg_last       - argument value and end-of-frame marker
//   res_valid/res_ready      - result handshake (res_valid is state-only)
//   res_data                 - frame sum, forced to 0 on arity error
//   res_err                  - frame length differed from ARITY
//   res_count                - arguments in the frame, saturating at 15
module arg_frame_collector #(
  parameter int ARITY = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_valid,
  output logic         arg_ready,
  input  logic [W-1:0] arg_data,
  input  logic         arg_last,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err,
  output logic [3:0]   res_count
);

  localparam logic [3:0] ARITY_CNT = 4'(ARITY);
  localparam logic [3:0] CNT_MAX   = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [3:0]   cnt_q, cnt_d;
  // Set once the true frame length has run past 15, so that a saturated count
  // that happens to equal ARITY is still reported as an arity error.
  logic         ovf_q, ovf_d;
  logic [W-1:0] res_data_q, res_data_d;
  logic         res_err_q, res_err_d;
  logic [3:0]   res_count_q, res_count_d;

  // Candidate accumulator/count values if the offered argument is accepted.
  logic         accept;
  logic         first;
  logic [W-1:0] acc_nxt;
  logic [3:0]   cnt_nxt;
  logic         ovf_nxt;
  logic         len_err;

  always_comb begin
    arg_ready = (state_q != RESULT);
    res_valid = (state_q == RESULT);
    accept    = arg_valid && arg_ready;
    first     = (state_q == IDLE);

    acc_nxt   = first ? arg_data : acc_q + arg_data;
    cnt_nxt   = first ? 4'd1 : ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 4'd1);
    ovf_nxt   = first ? 1'b0 : (ovf_q || (cnt_q == CNT_MAX));
    len_err   = ovf_nxt || (cnt_nxt != ARITY_CNT);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_count_d = res_count_q;

    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          acc_d = acc_nxt;
          cnt_d = cnt_nxt;
          ovf_d = ovf_nxt;
          if (arg_last) begin
            state_d     = RESULT;
            res_err_d   = len_err;
            res_data_d  = len_err ? '0 : acc_nxt;
            res_count_d = cnt_nxt;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      RESULT: begin
        // Result registers only change on consumption, keeping them stable
        // under backpressure.
        if (res_ready) begin
          state_d     = IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          res_data_d  = '0;
          res_err_d   = 1'b0;
          res_count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_count_q <= res_count_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_arg_frame_collector.sv
// tb_arg_frame_collector: directed scenarios plus randomized frames for
//   arg_frame_collector (ARITY=2, W=8), checked against a frame-level model.
// Inputs change on the falling edge; outputs are compared on the next one.
module tb_arg_frame_collector;

  localparam int ARITY = 2;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         arg_valid = 1'b0;
  logic         arg_ready;
  logic [W-1:0] arg_data = '0;
  logic         arg_last = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_err;
  logic [3:0]   res_count;

  int checks   = 0;
  int failures = 0;

  // Frame-level reference: arguments of the open frame, and the pending result.
  int m_n       = 0;
  int m_sum     = 0;
  bit m_pending = 1'b0;
  int m_data    = 0;
  int m_err     = 0;
  int m_cnt     = 0;
  int m_results = 0;

  arg_frame_collector #(.ARITY(ARITY), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .arg_valid (arg_valid),
    .arg_ready (arg_ready),
    .arg_data  (arg_data),
    .arg_last  (arg_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .res_count (res_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model; result fields only when presented.
  task automatic compare_all();
    chk("arg_ready", int'(arg_ready), int'(!m_pending));
    chk("res_valid", int'(res_valid), int'(m_pending));
    if (m_pending) begin
      chk("res_data", int'(res_data), m_data);
      chk("res_err", int'(res_err), m_err);
      chk("res_count", int'(res_count), m_cnt);
    end
  endtask

  function automatic void model_reset();
    m_n = 0;
    m_sum = 0;
    m_pending = 1'b0;
  endfunction

  // Drive one cycle of stimulus from a falling edge, predict the effect of
  // the coming rising edge, then compare on the following falling edge.
  task automatic tick(input bit v, input int d, input bit l, input bit r);
    arg_valid = v;
    arg_data  = W'(d);
    arg_last  = l;
    res_ready = r;
    if (m_pending) begin
      if (r) begin
        m_pending = 1'b0;
        m_results++;
      end
    end else if (v) begin
      m_n++;
      m_sum += d;
      if (l) begin
        m_err     = (m_n != ARITY) ? 1 : 0;
        m_data    = m_err ? 0 : (m_sum % (1 << W));
        m_cnt     = (m_n > 15) ? 15 : m_n;
        m_pending = 1'b1;
        m_n       = 0;
        m_sum     = 0;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset pulse strictly between clock edges.
  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1;
    chk("rst_arg_ready", int'(arg_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_err", int'(res_err), 0);
    chk("rst_res_count", int'(res_count), 0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_arg_ready", int'(arg_ready), 1);
    chk("reset_res_valid", int'(res_valid), 0);
    chk("reset_res_data", int'(res_data), 0);
    chk("reset_res_count", int'(res_count), 0);
    rst = 1'b0;
    model_reset();

    // Nominal two-argument frame.
    tick(1, 1, 0, 1);
    tick(1, 2, 1, 1);
    chk("s1_valid", int'(res_valid), 1);
    chk("s1_data", int'(res_data), 3);
    chk("s1_err", int'(res_err), 0);
    chk("s1_count", int'(res_count), 2);
    tick(0, 0, 0, 1);
    chk("s1_idle_ready", int'(arg_ready), 1);
    chk("s1_idle_valid", int'(res_valid), 0);

    // Too short.
    tick(1, 1, 1, 1);
    chk("short_err", int'(res_err), 1);
    chk("short_data", int'(res_data), 0);
    chk("short_count", int'(res_count), 1);
    tick(0, 0, 0, 1);

    // Too long.
    tick(1, 1, 0, 1);
    tick(1, 2, 0, 1);
    tick(1, 3, 1, 1);
    chk("long_err", int'(res_err), 1);
    chk("long_count", int'(res_count), 3);
    tick(0, 0, 0, 1);

    // Saturation: 20 arguments.
    for (int i = 0; i < 19; i++) tick(1, i + 1, 0, 1);
    tick(1, 20, 1, 1);
    chk("sat_count", int'(res_count), 15);
    chk("sat_err", int'(res_err), 1);
    tick(0, 0, 0, 1);

    // Wrap-around with held result under backpressure.
    tick(1, 'hF0, 0, 0);
    tick(1, 'h20, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1, 'h55, 1, 0);
      chk("bp_data", int'(res_data), 'h10);
      chk("bp_ready", int'(arg_ready), 0);
      chk("bp_valid", int'(res_valid), 1);
    end
    tick(0, 0, 0, 1);
    chk("bp_done_valid", int'(res_valid), 0);

    // Reset mid-frame; the stale 7 must not leak into the next frame.
    tick(1, 7, 0, 1);
    pulse_rst();
    tick(1, 4, 0, 1);
    tick(1, 5, 1, 1);
    chk("rstmid_data", int'(res_data), 9);
    chk("rstmid_err", int'(res_err), 0);
    tick(0, 0, 0, 1);

    // Reset while a result is pending discards it.
    tick(1, 3, 1, 0);
    chk("rstres_pre_valid", int'(res_valid), 1);
    pulse_rst();
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);

    // Randomized back-to-back frames with toggling valid/ready.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0) pulse_rst();
      tick(($urandom_range(0, 2) != 0),
           int'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1));
    end
    // Drain any pending result.
    tick(0, 0, 0, 1);

    chk("results_seen", int'(m_results > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arg_frame_collector.md
ARG_FRAME_COLLECTOR -- requirements
Module: arg_frame_collector

Interface
REQ-001 SHALL have parameter ARITY, default 2, giving the number of arguments a well-formed call frame must contain (legal range 1..15).
REQ-002 SHALL have parameter W, default 8, giving the argument and result data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port arg_valid, input, 1, upstream offers an argument.
REQ-006 SHALL have port arg_ready, output, 1, block accepts an argument this cycle.
REQ-007 SHALL have port arg_data, input, W, argument value.
REQ-008 SHALL have port arg_last, input, 1, the offered argument is the final one of its call frame.
REQ-009 SHALL have port res_valid, output, 1, a completed call result is presented.
REQ-010 SHALL have port res_ready, input, 1, downstream consumes the result.
REQ-011 SHALL have port res_data, output, W, sum of the frame's arguments modulo 2^W.
REQ-012 SHALL have port res_err, output, 1, frame argument count differed from ARITY.
REQ-013 SHALL have port res_count, output, 4, number of arguments received in the frame, saturating at 15.

Function
REQ-014 An argument SHALL be accepted only in a cycle where arg_valid and arg_ready are both 1.
REQ-015 The state machine SHALL have states IDLE, COLLECT and RESULT.
REQ-016 IDLE: arg_ready=1 and res_valid=0; an accepted argument with arg_last=0 SHALL go to COLLECT, and one with arg_last=1 SHALL go to RESULT.
REQ-017 COLLECT: arg_ready=1 and res_valid=0; an accepted argument with arg_last=1 SHALL go to RESULT, otherwise the block SHALL stay in COLLECT.
REQ-018 RESULT: arg_ready=0 and res_valid=1; when res_ready=1 the block SHALL go to IDLE, otherwise it SHALL stay in RESULT with every res_* output held stable.
REQ-019 Accumulation: the first argument of a frame SHALL load the accumulator, and each later argument SHALL be added modulo 2^W; carry out SHALL be discarded silently.
REQ-020 Count: the first argument of a frame SHALL load 1, and each later argument SHALL increment the count, saturating at 15 with no wrap.
REQ-021 On entering RESULT with count==ARITY, res_err SHALL be 0 and res_data SHALL equal the accumulator.
REQ-022 On entering RESULT with count!=ARITY (too few or too many arguments), res_err SHALL be 1 and res_data SHALL be 0.
REQ-023 In all cases res_count SHALL report the saturated count.
REQ-024 Latency: res_valid SHALL rise on the clock edge that accepts the arg_last argument, i.e. one cycle after acceptance.
REQ-025 arg_ready SHALL be 0 throughout RESULT, so no new frame starts until the result is consumed; there is no result/argument overlap.
REQ-026 arg_data and arg_last SHALL be ignored whenever arg_valid=0.
REQ-027 arg_ready SHALL NOT depend combinationally on arg_valid, and res_valid SHALL NOT depend combinationally on res_ready.

Reset
REQ-028 While rst=1, the block SHALL be in IDLE with arg_ready=1, res_valid=0, res_data=0, res_err=0, res_count=0, accumulator=0 and count=0, regardless of clk.
REQ-029 Assertion of rst mid-frame or during RESULT SHALL discard the partial or pending frame; no result for it SHALL ever appear.
REQ-030 After rst deasserts, the first accepted argument SHALL start a fresh frame.

Verification
REQ-031 Scenario, ARITY=2, W=8: args 1, 2(last), res_ready=1 -> one cycle later res_valid=1, res_data=3, res_err=0, res_count=2; IDLE on the next edge.
REQ-032 Scenario, arity short: single arg 1 with arg_last -> res_err=1, res_data=0, res_count=1.
REQ-033 Scenario, arity long plus saturation: args 1, 2, 3(last) -> res_err=1, res_count=3; a 20-argument frame -> res_count=15, res_err=1.
REQ-034 Scenario, wrap and backpressure: args 8'hF0, 8'h20(last) with res_ready=0 for 5 cycles -> res_data=8'h10 held stable and arg_ready=0 for all 5 cycles; the frame completes on the first cycle with res_ready=1.
REQ-035 Scenario, reset mid-frame: arg 7 accepted, rst pulsed asynchronously between edges, then args 4, 5(last) -> outputs zero immediately on rst; the result is 9 with res_err=0.
REQ-036 Scenario, back-to-back frames with arg_valid toggling randomly -> every frame result matches a reference model and no argument is lost or duplicated.
